m216a_freq_ramp_ctrl: RTL
=========================

M216A_FREQ_RAMP_CTRL -- requirements
Module: m216a_freq_ramp_ctrl

Interface
REQ-001 SHALL provide: clk  input  1  sole clock, all state on rising edge.
REQ-002 SHALL provide: rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL provide: tgt_valid  input  1  new target word offered.
REQ-004 SHALL provide: tgt_ready  output  1  controller can accept a target; high only in IDLE.
REQ-005 SHALL provide: tgt_i  input  4  target integer part.
REQ-006 SHALL provide: tgt_f  input  16  target fractional part, LSB = 1/65536.
REQ-007 SHALL provide: step  input  16  ramp step magnitude, LSB = 1/65536, sampled on accept.
REQ-008 SHALL provide: dwell  input  8  cycles between successive updates, sampled on accept; 0 treated as 1.
REQ-009 SHALL provide: abort  input  1  terminate an active ramp.
REQ-010 SHALL provide: out_i / out_f  output  4 / 16  registered word driving the MASH-111 modulator in_i / in_f.
REQ-011 SHALL provide: upd  output  1  one-cycle pulse in each cycle where out_i/out_f changed value.
REQ-012 SHALL provide: busy  output  1  high in RAMP and WAIT.
REQ-013 SHALL provide: done  output  1  one-cycle pulse on completion of a ramp.

Function
REQ-014 SHALL treat {out_i,out_f} as 20-bit unsigned word cur and {tgt_i,tgt_f} as target word tgt; all arithmetic 21-bit, no wrap, no over/undershoot of tgt.
REQ-015 SHALL implement states IDLE, RAMP, WAIT, DONE.
REQ-016 SHALL accept a target on a rising edge with tgt_valid & tgt_ready, latching tgt, step, dwell (0 -> 1) and moving IDLE -> RAMP; tgt_valid outside IDLE is ignored, not queued.
REQ-017 SHALL, in RAMP on the next edge: if |tgt-cur| <= step or step == 0 set cur = tgt and go DONE; else move cur toward tgt by step and go WAIT.
REQ-018 SHALL hold WAIT for dwell-1 cycles then return to RAMP, so successive updates are exactly dwell cycles apart.
REQ-019 SHALL, for accept at edge E0, produce first update at E1 and subsequent updates at E1 + n*dwell.
REQ-020 SHALL, when tgt equals cur on accept, still pass through RAMP (no cur change, upd low) then DONE.
REQ-021 SHALL assert done for the single cycle spent in DONE and return to IDLE on the following edge.
REQ-022 SHALL, on abort high in RAMP or WAIT, hold cur unchanged, go directly to IDLE, and not pulse done; abort in IDLE or DONE is ignored.
REQ-023 SHALL give abort priority over a step update on the same edge.
REQ-024 SHALL keep cur unchanged in IDLE and DONE.

Reset
REQ-025 SHALL, on rst high, immediately force state IDLE, out_i=0, out_f=0, upd=0, busy=0, done=0, latched target/step/dwell 0; tgt_ready=1 once rst deasserts.
REQ-026 SHALL abandon any ramp in progress on reset with no done pulse.
REQ-027 SHALL not accept a target while rst is high.

Configuration
REQ-028 SHALL, with M216A_RAMP_EN defined, ramp as in REQ-017..REQ-019.
REQ-029 SHALL, with M216A_RAMP_EN undefined, ignore step and dwell, set cur = tgt at E1, pulse upd (if changed), then DONE; WAIT state logic is not built.

Verification
REQ-030 SHALL cover: reset asserted mid-cycle -> out_i=0, out_f=0, upd/busy/done 0 immediately, tgt_ready 1 after release.
REQ-031 SHALL cover: from 0, tgt 8/32000, step 32768, dwell 4 -> 17 upd pulses at E1,E5..E65, final out 8/32000, done one cycle after E65, average of modulator output then within 8.48..8.50.
REQ-032 SHALL cover: from 8/32000, tgt 7/0, step 16384, dwell 1 -> 6 consecutive decreasing updates, last to exactly 7/0, done once.
REQ-033 SHALL cover: abort after third update of REQ-031 ramp -> out frozen at 1/32768, busy low next cycle, no done, tgt_ready 1.
REQ-034 SHALL cover: tgt_valid held high while busy with different word -> tgt_ready 0, word not taken, ramp completes to original target.
REQ-035 SHALL cover: step 0 or M216A_RAMP_EN undefined, tgt 15/65535 from 0 -> single upd at E1 to 15/65535, done next cycle.

Source files
------------

// File: rtl/m216a_freq_ramp_ctrl.sv
// rtl/m216a_freq_ramp_ctrl.sv - frequency-word ramp controller feeding a MASH-111 modulator
//
// Steps the registered word {out_i,out_f} toward an accepted target in
// increments of 'step', spaced 'dwell' cycles apart. Build option:
// M216A_RAMP_EN (defined: stepped ramp; undefined: jump straight to target).
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   tgt_valid/ready   target handshake (ready only in IDLE)
//   tgt_i, tgt_f      target word, integer 4b / fraction 16b
//   step, dwell       ramp step (LSB 1/65536) and update spacing, sampled on accept
//   abort             stop an active ramp, word frozen
//   out_i, out_f      current word to the modulator
//   upd, busy, done   update pulse, ramp active, completion pulse

module m216a_freq_ramp_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        tgt_valid,
  output logic        tgt_ready,
  input  logic [3:0]  tgt_i,
  input  logic [15:0] tgt_f,
  input  logic [15:0] step,
  input  logic [7:0]  dwell,
  input  logic        abort,
  output logic [3:0]  out_i,
  output logic [15:0] out_f,
  output logic        upd,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {S_IDLE, S_RAMP, S_WAIT, S_DONE} state_t;

  state_t      state;
  logic [19:0] cur;
  logic [19:0] tgt_q;
  logic [19:0] next_cur;
  logic        ramp_last;
  logic        accept;

  assign {out_i, out_f} = cur;
  // Gated with rst so nothing can be taken while reset is held.
  assign tgt_ready = (state == S_IDLE) & ~rst;
  assign accept    = tgt_valid & tgt_ready;

`ifdef M216A_RAMP_EN
  logic [15:0] step_q;
  logic [7:0]  dwell_q;
  logic [7:0]  wcnt;
  logic [20:0] diff;
  logic [20:0] moved;

  // 21-bit distance and step so the final step can clamp exactly to the target.
  always_comb begin
    diff      = 21'd0;
    moved     = 21'd0;
    ramp_last = 1'b0;
    next_cur  = tgt_q;
    if (tgt_q >= cur) begin
      diff  = {1'b0, tgt_q} - {1'b0, cur};
      moved = {1'b0, cur} + {5'd0, step_q};
    end else begin
      diff  = {1'b0, cur} - {1'b0, tgt_q};
      moved = {1'b0, cur} - {5'd0, step_q};
    end
    ramp_last = (step_q == 16'd0) || (diff <= {5'd0, step_q});
    if (!ramp_last) next_cur = moved[19:0];
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{step, dwell};
  assign ramp_last  = 1'b1;
  assign next_cur   = tgt_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      cur     <= 20'd0;
      tgt_q   <= 20'd0;
      upd     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef M216A_RAMP_EN
      step_q  <= 16'd0;
      dwell_q <= 8'd0;
      wcnt    <= 8'd0;
`endif
    end else begin
      upd  <= 1'b0;
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            tgt_q   <= {tgt_i, tgt_f};
`ifdef M216A_RAMP_EN
            step_q  <= step;
            dwell_q <= (dwell == 8'd0) ? 8'd1 : dwell;
`endif
            state   <= S_RAMP;
            busy    <= 1'b1;
          end
        end
        S_RAMP: begin
          if (abort) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            cur <= next_cur;
            upd <= (next_cur != cur);
            if (ramp_last) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
`ifdef M216A_RAMP_EN
            // dwell of 1 updates every cycle, so WAIT is skipped entirely.
            else if (dwell_q == 8'd1) begin
              state <= S_RAMP;
            end else begin
              state <= S_WAIT;
              wcnt  <= dwell_q - 8'd2;
            end
`endif
          end
        end
`ifdef M216A_RAMP_EN
        S_WAIT: begin
          if (abort) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (wcnt == 8'd0) begin
            state <= S_RAMP;
          end else begin
            wcnt <= wcnt - 8'd1;
          end
        end
`endif
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
